race_screen_fsm: RTL
====================

RACE_SCREEN_FSM -- requirements
Module: race_screen_fsm

Interface
REQ-001 SHALL have parameter MAX_POS, default 109, number of LED positions per lane; finish position is MAX_POS-1.
REQ-002 SHALL have parameter COUNTDOWN_STEP_CYCLES, default 25_000_000, duration of each countdown digit in clk cycles.
REQ-003 SHALL have parameter FINISH_HOLD_CYCLES, default 100_000_000, duration of finish screen in clk cycles.
REQ-004 SHALL have ports:
  clk  input  1  single system clock, all logic on rising edge
  rst  input  1  reset, synchronous, active-high
  start_btn  input  1  level, OR of player start buttons, already synchronised
  game_finished  input  1  level from upstream finish detector, gated by is_in_menu
  green_cur_pos  input  $clog2(MAX_POS)  green lane position
  red_cur_pos  input  $clog2(MAX_POS)  red lane position
  blue_cur_pos  input  $clog2(MAX_POS)  blue lane position
  yellow_cur_pos  input  $clog2(MAX_POS)  yellow lane position
  is_in_menu  output  1  high in MENU state
  race_active  output  1  high in RACE state; position counters advance only when high
  countdown_val  output  2  current countdown digit 3/2/1, 0 outside COUNTDOWN
  finish_screen  output  1  high in FINISHED state
  winner  output  4  one-hot {yellow,blue,red,green}, bit0 = green
  winner_valid  output  1  high while winner holds a captured result

Function
REQ-005 SHALL implement states MENU, COUNTDOWN, RACE, FINISHED, held in a state register; all outputs registered or decoded from registers only (no combinational path input->output).
REQ-006 SHALL register start_btn each cycle; start event = start_btn high and previous sample low.
REQ-007 MENU: start event SHALL move to COUNTDOWN (or RACE, see REQ-016) next cycle and clear winner and winner_valid in that same cycle.
REQ-008 COUNTDOWN: countdown_val SHALL show 3, 2, 1, each for exactly COUNTDOWN_STEP_CYCLES cycles, then state becomes RACE; countdown_val returns to 0 on RACE entry.
REQ-009 RACE: game_finished sampled high at edge N SHALL make finish_screen=1, winner_valid=1, race_active=0 from cycle N+1.
REQ-010 Winner capture SHALL set bit for each lane whose position equals MAX_POS-1 at edge N, then keep only the highest-priority bit: green > red > blue > yellow.
REQ-011 If game_finished high but no lane equals MAX_POS-1, SHALL still enter FINISHED with winner=0 and winner_valid=0.
REQ-012 FINISHED SHALL last exactly FINISH_HOLD_CYCLES cycles, then return to MENU; winner and winner_valid retained in MENU until next start event.
REQ-013 Start events in COUNTDOWN, RACE and FINISHED SHALL be ignored and not queued; button held across FINISHED->MENU SHALL NOT start a race (edge required).
REQ-014 game_finished in MENU or COUNTDOWN SHALL be ignored.
REQ-015 Timers SHALL be sized $clog2 of largest cycle count +1 bits, reset to 0 on every state entry, never wrap.

Configuration
REQ-016 Macro RACE_COUNTDOWN_EN: defined -> COUNTDOWN state and REQ-008 present; undefined -> MENU start event goes directly to RACE, countdown_val tied to 0, countdown timer not built.

Reset
REQ-017 rst high at any clock edge, in any state including mid-countdown or mid-hold, SHALL force next cycle: state MENU, is_in_menu=1, race_active=0, countdown_val=0, finish_screen=0, winner=0, winner_valid=0, timers 0.
REQ-018 Registered start_btn sample SHALL reset to 1, so a button held through reset produces no start event.

Verification (MAX_POS=109, COUNTDOWN_STEP_CYCLES=4, FINISH_HOLD_CYCLES=8)
REQ-019 Reset release, pulse start_btn 1 cycle -> next cycle is_in_menu=0, countdown_val=3; 3,2,1 for 4 cycles each; race_active=1 after 12 cycles (macro defined).
REQ-020 In RACE set red_cur_pos=108, game_finished=1 -> next cycle finish_screen=1, winner=4'b0010, winner_valid=1; after 8 cycles is_in_menu=1, winner still 4'b0010.
REQ-021 In RACE green=108 and yellow=108 same edge with game_finished=1 -> winner=4'b0001.
REQ-022 Hold start_btn high through reset and FINISHED->MENU transition -> state stays MENU; release and press again -> race starts.
REQ-023 Assert rst during countdown_val=2 -> next cycle is_in_menu=1, countdown_val=0; rebuild without RACE_COUNTDOWN_EN -> start pulse gives race_active=1 next cycle, countdown_val always 0.

Source files
------------

// File: rtl/race_screen_fsm.sv
`default_nettype none
// ============================================================================
// Module      : race_screen_fsm
// Description : Top-level screen sequencer for the LED race game.
//               Walks MENU -> (COUNTDOWN) -> RACE -> FINISHED -> MENU,
//               captures the winning lane when the finish detector fires and
//               keeps that result on display until the next race starts.
//
// Optional feature macro: RACE_COUNTDOWN_EN
//   defined   : a 3/2/1 countdown screen sits between MENU and RACE
//   undefined : a start event in MENU goes straight to RACE, countdown_val
//               is tied to 0 and no countdown timer is built
//
// Ports
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   start_btn       level, OR of the player start buttons (already synced)
//   game_finished   level from the upstream finish detector
//   *_cur_pos       current LED position of each lane
//   is_in_menu      high in MENU
//   race_active     high in RACE; lane counters may only advance then
//   countdown_val   current countdown digit 3/2/1, 0 outside COUNTDOWN
//   finish_screen   high in FINISHED
//   winner          one-hot {yellow,blue,red,green}, bit0 = green
//   winner_valid    high while winner holds a captured result
//
// Revision    : 1.0 - initial release
// ============================================================================
module race_screen_fsm #(
    parameter int MAX_POS               = 109,
    parameter int COUNTDOWN_STEP_CYCLES = 25_000_000,
    parameter int FINISH_HOLD_CYCLES    = 100_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_btn,
    input  logic                       game_finished,
    input  logic [$clog2(MAX_POS)-1:0] green_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] red_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] blue_cur_pos,
    input  logic [$clog2(MAX_POS)-1:0] yellow_cur_pos,
    output logic                       is_in_menu,
    output logic                       race_active,
    output logic [1:0]                 countdown_val,
    output logic                       finish_screen,
    output logic [3:0]                 winner,
    output logic                       winner_valid
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_POS_W  = $clog2(MAX_POS);
    localparam int c_HOLD_W = $clog2(FINISH_HOLD_CYCLES + 1);

    localparam logic [c_POS_W-1:0]  c_FINISH_POS = c_POS_W'(MAX_POS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST  = c_HOLD_W'(FINISH_HOLD_CYCLES - 1);

    localparam logic [1:0] c_ST_MENU     = 2'd0;
`ifdef RACE_COUNTDOWN_EN
    localparam logic [1:0] c_ST_COUNTDOWN = 2'd1;
`endif
    localparam logic [1:0] c_ST_RACE     = 2'd2;
    localparam logic [1:0] c_ST_FINISHED = 2'd3;

`ifdef RACE_COUNTDOWN_EN
    localparam int c_CD_W = $clog2(COUNTDOWN_STEP_CYCLES + 1);
    localparam logic [c_CD_W-1:0] c_CD_LAST = c_CD_W'(COUNTDOWN_STEP_CYCLES - 1);
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state_q,        w_state_d;
    logic                r_start_q;
    logic [3:0]          r_winner_q,       w_winner_d;
    logic                r_winner_valid_q, w_winner_valid_d;
    logic [c_HOLD_W-1:0] r_hold_tmr_q,     w_hold_tmr_d;
`ifdef RACE_COUNTDOWN_EN
    logic [c_CD_W-1:0]   r_cd_tmr_q,       w_cd_tmr_d;
    logic [1:0]          r_cd_val_q,       w_cd_val_d;
`endif

    logic       w_start_evt;
    logic [3:0] w_lane_hit;
    logic [3:0] w_winner_pick;

    // Rising edge of the button level. The previous sample resets to 1 so a
    // button that is held while reset is released never counts as a press.
    assign w_start_evt = start_btn & ~r_start_q;

    // One bit per lane sitting on the finish LED, {yellow,blue,red,green}.
    assign w_lane_hit = {yellow_cur_pos == c_FINISH_POS,
                         blue_cur_pos   == c_FINISH_POS,
                         red_cur_pos    == c_FINISH_POS,
                         green_cur_pos  == c_FINISH_POS};

    // Ties are broken green > red > blue > yellow, i.e. lowest bit wins.
    always_comb begin
        w_winner_pick = 4'b0000;
        if (w_lane_hit[0]) begin
            w_winner_pick = 4'b0001;
        end else if (w_lane_hit[1]) begin
            w_winner_pick = 4'b0010;
        end else if (w_lane_hit[2]) begin
            w_winner_pick = 4'b0100;
        end else if (w_lane_hit[3]) begin
            w_winner_pick = 4'b1000;
        end
    end

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q        <= c_ST_MENU;
            r_start_q        <= 1'b1;
            r_winner_q       <= 4'b0000;
            r_winner_valid_q <= 1'b0;
            r_hold_tmr_q     <= '0;
`ifdef RACE_COUNTDOWN_EN
            r_cd_tmr_q       <= '0;
            r_cd_val_q       <= 2'd0;
`endif
        end else begin
            r_state_q        <= w_state_d;
            r_start_q        <= start_btn;
            r_winner_q       <= w_winner_d;
            r_winner_valid_q <= w_winner_valid_d;
            r_hold_tmr_q     <= w_hold_tmr_d;
`ifdef RACE_COUNTDOWN_EN
            r_cd_tmr_q       <= w_cd_tmr_d;
            r_cd_val_q       <= w_cd_val_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d        = r_state_q;
        w_winner_d       = r_winner_q;
        w_winner_valid_d = r_winner_valid_q;
        w_hold_tmr_d     = r_hold_tmr_q;
`ifdef RACE_COUNTDOWN_EN
        w_cd_tmr_d       = r_cd_tmr_q;
        w_cd_val_d       = r_cd_val_q;
`endif

        case (r_state_q)
            c_ST_MENU: begin
                // The previous result stays on screen until a new race is
                // requested; it is dropped in the same cycle as the start.
                if (w_start_evt) begin
                    w_winner_d       = 4'b0000;
                    w_winner_valid_d = 1'b0;
`ifdef RACE_COUNTDOWN_EN
                    w_state_d        = c_ST_COUNTDOWN;
                    w_cd_tmr_d       = '0;
                    w_cd_val_d       = 2'd3;
`else
                    w_state_d        = c_ST_RACE;
`endif
                end
            end

`ifdef RACE_COUNTDOWN_EN
            c_ST_COUNTDOWN: begin
                // The step timer restarts for each digit; the terminal
                // compare keeps it from ever wrapping.
                if (r_cd_tmr_q == c_CD_LAST) begin
                    w_cd_tmr_d = '0;
                    if (r_cd_val_q == 2'd1) begin
                        w_state_d  = c_ST_RACE;
                        w_cd_val_d = 2'd0;
                    end else begin
                        w_cd_val_d = r_cd_val_q - 2'd1;
                    end
                end else begin
                    w_cd_tmr_d = r_cd_tmr_q + 1'b1;
                end
            end
`endif

            c_ST_RACE: begin
                // Winner is taken from the lane positions seen on the same
                // edge that samples game_finished. With no lane on the
                // finish LED the race still ends, just without a winner.
                if (game_finished) begin
                    w_state_d        = c_ST_FINISHED;
                    w_hold_tmr_d     = '0;
                    w_winner_d       = w_winner_pick;
                    w_winner_valid_d = |w_lane_hit;
                end
            end

            c_ST_FINISHED: begin
                if (r_hold_tmr_q == c_HOLD_LAST) begin
                    w_state_d    = c_ST_MENU;
                    w_hold_tmr_d = '0;
                end else begin
                    w_hold_tmr_d = r_hold_tmr_q + 1'b1;
                end
            end

            default: begin
                w_state_d    = c_ST_MENU;
                w_hold_tmr_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs, decoded from registers only
    // ------------------------------------------------------------------------
    always_comb begin
        is_in_menu    = (r_state_q == c_ST_MENU);
        race_active   = (r_state_q == c_ST_RACE);
        finish_screen = (r_state_q == c_ST_FINISHED);
        winner        = r_winner_q;
        winner_valid  = r_winner_valid_q;
`ifdef RACE_COUNTDOWN_EN
        countdown_val = r_cd_val_q;
`else
        countdown_val = 2'd0;
`endif
    end

endmodule
`default_nettype wire
